// File: rtl/mem_req_initiator_pkg.sv
// Shared types and default constants for the memory request initiator.
// The FSM encoding is 2 bits wide and is visible on the top-level debug port.
package mem_req_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDRESSLENGTH = 16;
  localparam int unsigned DEF_DATALENGTH    = 32;
  localparam int unsigned DEF_CMD_DEPTH     = 4;
  localparam int unsigned DEF_TIMEOUT       = 64;

endpackage

// File: rtl/req_cmd_fifo.sv
// Command FIFO with full/empty flags. Pointers carry one extra wrap bit;
// a push while full is accepted when a pop happens in the same cycle.
module req_cmd_fifo #(
  parameter int unsigned WIDTH = 49,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  // DEPTH is expected to be a power of two, at least 2.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mem_req_initiator.sv
// Queues CPU-side commands and issues them one at a time to a cache controller,
// returning one response record per access (with timeout error) in FIFO order.
module mem_req_initiator
  import mem_req_initiator_pkg::*;
#(
  parameter int unsigned ADDRESSLENGTH = DEF_ADDRESSLENGTH,
  parameter int unsigned DATALENGTH    = DEF_DATALENGTH,
  parameter int unsigned CMD_DEPTH     = DEF_CMD_DEPTH,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDRESSLENGTH-1:0] cmd_addr,
  input  logic [DATALENGTH-1:0]    cmd_wdata,
  output logic                     cpu_re,
  output logic                     cpu_we,
  output logic [ADDRESSLENGTH-1:0] cpu_addr,
  output logic [DATALENGTH-1:0]    cpu_wdata,
  input  logic [DATALENGTH-1:0]    cpu_rdata,
  input  logic                     cpu_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATALENGTH-1:0]    resp_rdata,
  output logic [ADDRESSLENGTH-1:0] resp_addr,
  output logic                     resp_we,
  output logic                     resp_err,
  output logic                     busy,
  output state_e                   state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the source holds valid and payload stable until that edge.

  localparam int unsigned CMD_W = 1 + ADDRESSLENGTH + DATALENGTH;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     req_q;
  logic                     we_q;
  logic [ADDRESSLENGTH-1:0] cpu_addr_q;
  logic [DATALENGTH-1:0]    cpu_wdata_q;
  logic                     resp_valid_q;
  logic [DATALENGTH-1:0]    resp_rdata_q;
  logic [ADDRESSLENGTH-1:0] resp_addr_q;
  logic                     resp_we_q;
  logic                     resp_err_q;

  logic [CMD_W-1:0]         head;
  logic                     head_we;
  logic [ADDRESSLENGTH-1:0] head_addr;
  logic [DATALENGTH-1:0]    head_wdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic                     resp_pop;

  req_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i ({cmd_we, cmd_addr, cmd_wdata}),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_we, head_addr, head_wdata} = head;

  assign resp_pop  = resp_valid_q && resp_ready;
  // Only issue when the single response slot is free by the time this access completes.
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty && (!resp_valid_q || resp_ready);
  assign cmd_ready = !fifo_full || fifo_pop;

  // Gated by cpu_ready so the controller never sees a request in its completion cycle.
  assign cpu_re     = req_q && !we_q && !cpu_ready;
  assign cpu_we     = req_q &&  we_q && !cpu_ready;
  assign cpu_addr   = cpu_addr_q;
  assign cpu_wdata  = cpu_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_addr  = resp_addr_q;
  assign resp_we    = resp_we_q;
  assign resp_err   = resp_err_q;
  assign busy       = !fifo_empty || (state_q != ST_IDLE) || resp_valid_q;
  assign state_o    = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_addr_q  <= '0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      if (resp_pop) resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            cpu_addr_q  <= head_addr;
            cpu_wdata_q <= head_wdata;
            we_q        <= head_we;
            req_q       <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cpu_ready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            req_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= (cpu_ready && !we_q) ? cpu_rdata : '0;
            resp_addr_q  <= cpu_addr_q;
            resp_we_q    <= we_q;
            resp_err_q   <= !cpu_ready;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
